// File: rtl/next_state_sequencer.sv
// Microsequencer next-state logic: selects the following microstore state from the
// control word, condition and moc, and aborts moc waits that exceed MOC_TIMEOUT edges.
module next_state_sequencer #(
  parameter int         MOC_TIMEOUT = 15,
  parameter logic [6:0] ERR_STATE   = 7'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] N,
  input  logic [6:0] CR,
  input  logic       inv,
  input  logic       cond,
  input  logic       moc,
  input  logic [6:0] encState,
  output logic [6:0] currentState,
  output logic       timeout
);

  // Counter wide enough for MOC_TIMEOUT-1, never narrower than 4 bits.
  localparam int WCW = (MOC_TIMEOUT < 16) ? 4 : $clog2(MOC_TIMEOUT + 1);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(MOC_TIMEOUT - 1);

  logic [6:0]     state_reg, state_next;
  logic [WCW-1:0] wait_cnt_reg, wait_cnt_next;
  logic           timeout_reg, timeout_next;
  logic           c;
  logic [6:0]     inc;
  logic           hold;

  assign c    = cond ^ inv;
  assign inc  = state_reg + 7'd1;
  assign hold = (N[2:1] == 2'b11) && !moc;

  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = '0;
    timeout_next  = 1'b0;
    unique case (N)
      3'b000: state_next = encState;
      3'b001: state_next = 7'd0;
      3'b010: state_next = CR;
      3'b011: state_next = inc;
      3'b100: state_next = c ? CR : inc;
      3'b101: state_next = c ? CR : encState;
      3'b110: state_next = moc ? inc : state_reg;
      3'b111: state_next = moc ? CR : state_reg;
      default: state_next = state_reg;
    endcase
    // A hold that would exceed the wait budget becomes an abort to ERR_STATE.
    if (hold) begin
      if (wait_cnt_reg == WAIT_LAST) begin
        state_next   = ERR_STATE;
        timeout_next = 1'b1;
      end else begin
        wait_cnt_next = wait_cnt_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= 7'd0;
      wait_cnt_reg <= '0;
      timeout_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      timeout_reg  <= timeout_next;
    end
  end

  assign currentState = state_reg;
  assign timeout      = timeout_reg;

endmodule

// File: tb/tb_next_state_sequencer.sv
// Scoreboard bench: driver issues control words and queues the reference model's
// expected state/timeout; a monitor pops and compares after every rising edge.
module tb_next_state_sequencer;

  localparam int         MOC_TIMEOUT = 15;
  localparam logic [6:0] ERR_STATE   = 7'd0;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] N;
  logic [6:0] CR;
  logic       inv, cond, moc;
  logic [6:0] encState;
  logic [6:0] currentState;
  logic       timeout;

  next_state_sequencer #(.MOC_TIMEOUT(MOC_TIMEOUT), .ERR_STATE(ERR_STATE)) dut (
    .clk(clk), .reset(reset), .N(N), .CR(CR), .inv(inv), .cond(cond), .moc(moc),
    .encState(encState), .currentState(currentState), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   txn;
    int   st;
    logic to;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   txn_id   = 0;

  // Reference model: plain integer state and a count of consecutive holds.
  int m_state = 0;
  int m_holds = 0;

  task automatic drive(input bit r, input int n, input int cr, input bit iv,
                       input bit cd, input bit mc, input int enc);
    int   nxt;
    bit   eff;
    bit   wants_hold;
    logic to;
    exp_t e;
    @(negedge clk);
    reset = r; N = 3'(n); CR = 7'(cr); inv = iv; cond = cd; moc = mc; encState = 7'(enc);
    eff = cd != iv;
    to  = 1'b0;
    if (r) begin
      m_state = 0;
      m_holds = 0;
    end else begin
      wants_hold = (n >= 6) && !mc;
      case (n)
        0: nxt = enc;
        1: nxt = 0;
        2: nxt = cr;
        3: nxt = (m_state + 1) % 128;
        4: nxt = eff ? cr : (m_state + 1) % 128;
        5: nxt = eff ? cr : enc;
        6: nxt = mc ? (m_state + 1) % 128 : m_state;
        default: nxt = mc ? cr : m_state;
      endcase
      if (wants_hold && m_holds + 1 >= MOC_TIMEOUT) begin
        nxt     = int'(ERR_STATE);
        to      = 1'b1;
        m_holds = 0;
      end else begin
        m_holds = wants_hold ? m_holds + 1 : 0;
      end
      m_state = nxt;
    end
    e.txn = txn_id; e.st = m_state; e.to = to;
    q.push_back(e);
    txn_id++;
  endtask

  // Monitor: the DUT presents a new state after every rising edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      n_checks++;
      if (currentState !== 7'(e.st)) begin
        n_fail++;
        $display("FAIL state txn %0d: got %0d expected %0d", e.txn, currentState, e.st);
      end
      n_checks++;
      if (timeout !== e.to) begin
        n_fail++;
        $display("FAIL timeout txn %0d: got %b expected %b", e.txn, timeout, e.to);
      end
      $display("txn %0d: state=%0d timeout=%b (exp %0d/%b)", e.txn, currentState, timeout, e.st, e.to);
    end
  end

  initial begin
    reset = 1'b1; N = 3'd0; CR = 7'd0; inv = 1'b0; cond = 1'b0; moc = 1'b0; encState = 7'd0;

    // Reset for two edges, then count up.
    drive(1, 3, 0, 0, 0, 0, 0);
    drive(1, 3, 0, 0, 0, 0, 0);
    repeat (3) drive(0, 3, 0, 0, 0, 0, 0);

    // Conditional branches.
    drive(0, 0, 0, 0, 0, 0, 4);
    drive(0, 4, 10, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 4);
    drive(0, 4, 10, 1, 1, 0, 0);
    drive(0, 5, 10, 0, 0, 0, 20);

    // Short wait-increment resolved by moc.
    drive(0, 0, 0, 0, 0, 0, 9);
    repeat (3) drive(0, 6, 0, 0, 0, 0, 0);
    drive(0, 6, 0, 0, 0, 1, 0);

    // Wait-branch timing out, then timeout must drop.
    drive(0, 0, 0, 0, 0, 0, 12);
    repeat (15) drive(0, 7, 33, 0, 0, 0, 0);
    drive(0, 3, 0, 0, 0, 0, 0);

    // moc on the 15th edge wins over timeout.
    drive(0, 0, 0, 0, 0, 0, 12);
    repeat (14) drive(0, 7, 33, 0, 0, 0, 0);
    drive(0, 7, 33, 0, 0, 1, 0);

    // Reset mid-wait clears the counter; a fresh full wait follows.
    drive(0, 0, 0, 0, 0, 0, 12);
    repeat (4) drive(0, 7, 33, 0, 0, 0, 0);
    drive(1, 7, 33, 0, 0, 0, 0);
    repeat (15) drive(0, 7, 33, 0, 0, 0, 0);

    // Wrap and explicit zero.
    drive(0, 0, 0, 0, 0, 0, 127);
    drive(0, 3, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 77);
    drive(0, 1, 0, 0, 0, 0, 0);

    // Random traffic, biased toward long waits.
    for (int i = 0; i < 800; i++) begin
      bit rb, mb;
      int nn;
      rb = ($urandom_range(0, 99) == 0);
      nn = ($urandom_range(0, 1) == 0) ? $urandom_range(6, 7) : $urandom_range(0, 7);
      mb = ($urandom_range(0, 15) == 0);
      drive(rb, nn, $urandom_range(0, 127), $urandom_range(0, 1), $urandom_range(0, 1),
            mb, $urandom_range(0, 127));
    end

    // Drain the scoreboard within a bounded number of edges.
    for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/next_state_sequencer.md
NEXT_STATE_SEQUENCER -- requirements
Module: next_state_sequencer

Interface
REQ-001 SHALL have parameter MOC_TIMEOUT, default 15: maximum cycles spent waiting on moc before abort.
REQ-002 SHALL have parameter ERR_STATE, default 7'd0: state loaded on moc timeout.
REQ-003 SHALL have port clk  input  1: single clock, all state updates on rising edge.
REQ-004 SHALL have port reset  input  1: reset, synchronous and active-high.
REQ-005 SHALL have port N  input  3: next-state select field from microstore control word.
REQ-006 SHALL have port CR  input  7: control-register target state from microstore control word.
REQ-007 SHALL have port inv  input  1: condition inversion bit from microstore control word.
REQ-008 SHALL have port cond  input  1: raw condition-tester output.
REQ-009 SHALL have port moc  input  1: memory operation complete from RAM.
REQ-010 SHALL have port encState  input  7: first execute state from instruction encoder.
REQ-011 SHALL have port currentState  output  7: registered state number driven to microstore.
REQ-012 SHALL have port timeout  output  1: one-cycle pulse when a moc wait is aborted.

Function
REQ-013 SHALL compute effective condition c = cond XOR inv, combinationally.
REQ-014 SHALL compute inc = currentState + 1, 7-bit, wrapping 127 -> 0.
REQ-015 SHALL select next state by N: 000 encState; 001 7'd0; 010 CR; 011 inc.
REQ-016 SHALL select for N=100: c ? CR : inc.
REQ-017 SHALL select for N=101: c ? CR : encState.
REQ-018 SHALL select for N=110 (wait-increment): moc ? inc : currentState (hold).
REQ-019 SHALL select for N=111 (wait-branch): moc ? CR : currentState (hold).
REQ-020 SHALL load the selected next state into currentState every rising edge; one-cycle latency from inputs to currentState.
REQ-021 SHALL keep a 4-bit-minimum wait counter, incremented each edge on which N is 110/111 and moc=0 (hold taken).
REQ-022 SHALL clear the wait counter on any edge where a hold is not taken (moc=1 or N not 11x).
REQ-023 SHALL, on the edge where a hold would be taken with wait counter = MOC_TIMEOUT-1, load ERR_STATE instead, clear the counter, and assert timeout for exactly that following cycle.
REQ-024 SHALL give moc=1 priority over timeout when both fall on the same edge (normal advance, no timeout).
REQ-025 SHALL treat c as don't-care for N=000,001,010,011,110,111 and moc as don't-care for N=0xx,10x.
REQ-026 SHALL deassert timeout on every cycle other than REQ-023's.
REQ-027 SHALL be free of latches; no X on outputs for any 3-bit N value.

Reset
REQ-028 SHALL, on an edge with reset=1, set currentState=7'd0, wait counter=0, timeout=0, overriding all other inputs.
REQ-029 SHALL abandon any wait in progress on reset, with no timeout pulse generated.
REQ-030 SHALL resume normal selection on the first edge after reset deasserts, starting from state 0.

Verification
REQ-031 Reset held 2 cycles, N=011 -> currentState=0 during reset, then 1,2,3 on successive edges; timeout=0 throughout.
REQ-032 currentState=4, N=100, CR=7'd10, cond=1, inv=0 -> 10; repeat with inv=1 -> 5; N=101, cond=0, inv=0, encState=7'd20 -> 20.
REQ-033 currentState=9, N=110, moc=0 for 3 edges then 1 -> holds 9 for 3 edges, then 10; timeout stays 0; counter back to 0.
REQ-034 currentState=12, N=111, CR=7'd33, moc=0 for 15 edges -> 12 held 14 edges, then ERR_STATE (0) with timeout=1 for one cycle only.
REQ-035 Same wait with moc=1 arriving on the 15th edge -> 33, no timeout; reset asserted mid-wait on edge 5 -> 0, no timeout, counter 0.
REQ-036 currentState=127, N=011 -> 0 (wrap); N=001 from any state -> 0.
